qsort_range_stack: RTL

- Parametrised range-stack controller for the iterative quicksort datapath. Successor to the single-register pivot-range tracker.
- Holds pending [lo,hi] sub-array ranges in an explicit LIFO of configurable depth. Issues one range at a time to the partition engine over a valid/ready handshake.
- Accepts the resulting pivot index and pushes the non-trivial sub-ranges, larger first, so the smaller one is sorted next.
- Adds overflow and bad-pivot detection, a sticky error flag, and a done indication that holds until the next start.

---
 rtl/qsort_pkg.sv | 29 ++
 rtl/range_lifo.sv | 62 ++++++
 rtl/qsort_range_stack.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/qsort_pkg.sv
// Shared types for the quicksort range-stack controller: FSM encoding,
// index-width helper and the stored [lo,hi] range record.
package qsort_pkg;

    // Internal range arithmetic width; wide enough that lo+1 and p+1 never
    // wrap for any practical K.
    localparam int RW = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_OFFER      = 3'd2,
        ST_WAIT_PIVOT = 3'd3,
        ST_PUSH_A     = 3'd4,
        ST_PUSH_B     = 3'd5,
        ST_DONE       = 3'd6
    } state_e;

    typedef struct packed {
        logic [RW-1:0] lo;
        logic [RW-1:0] hi;
    } range_t;

    // Index/count width for a K-element array.
    function automatic int idx_w(input int k);
        return $clog2(k) + 1;
    endfunction

endpackage

// File: rtl/range_lifo.sv
// DEPTH-entry LIFO of [lo,hi] ranges with clear, push, pop and occupancy.
module range_lifo
    import qsort_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  range_t        din,
    output range_t        dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    range_t          mem_q [DEPTH];
    range_t          mem_d [DEPTH];
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   cnt_base;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;

    assign full   = (cnt_q == LW'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign level  = cnt_q;
    assign rd_idx = IW'(cnt_q - LW'(1));
    assign dout   = empty ? '0 : mem_q[rd_idx];

    // Clear takes effect first so a clear+push lands the entry in slot 0.
    always_comb begin
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        cnt_base = clr ? '0 : cnt_q;
        wr_idx   = IW'(cnt_base);
        if (push && (cnt_base != LW'(DEPTH))) begin
            mem_d[wr_idx] = din;
            cnt_d         = cnt_base + LW'(1);
        end else if (clr) begin
            cnt_d = '0;
        end else if (pop && !empty) begin
            cnt_d = cnt_q - LW'(1);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/qsort_range_stack.sv
// Range-stack controller for iterative quicksort: issues [lo,hi] ranges to the
// partition engine and pushes the non-trivial sub-ranges, larger first.
module qsort_range_stack
    import qsort_pkg::*;
#(
    parameter  int K     = 10,
    parameter  int DEPTH = 8,
    localparam int S     = idx_w(K),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          range_valid,
    input  logic          range_ready,
    output logic [S-1:0]  range_lo,
    output logic [S-1:0]  range_hi,
    output logic [S-1:0]  range_cnt,
    input  logic          pivot_valid,
    input  logic [S-1:0]  pivot_idx,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [LW-1:0] level
);

    state_e         state_q, state_d;
    logic [RW-1:0]  lo_q, lo_d, hi_q, hi_d;
    range_t         pa_q, pa_d, pb_q, pb_d;
    logic           err_q, err_d;

    logic           st_clr, st_push, st_pop, st_full, st_empty;
    range_t         push_data, top;

    logic [RW-1:0]  p;
    logic           l_ok, r_ok, bad;
    logic [RW-1:0]  l_sz, r_sz;
    range_t         left_r, right_r;

    range_lifo #(.DEPTH(DEPTH)) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (st_clr),
        .push  (st_push),
        .pop   (st_pop),
        .din   (push_data),
        .dout  (top),
        .full  (st_full),
        .empty (st_empty),
        .level (level)
    );

    // Sub-range qualification: compare in the wide domain before any
    // subtraction, so p=0 or p=hi never produces a wrapped bound.
    always_comb begin
        p          = RW'(pivot_idx);
        bad        = (p < lo_q) || (p > hi_q);
        l_ok       = (p > lo_q + RW'(1));
        r_ok       = (hi_q > p + RW'(1));
        l_sz       = p - lo_q;
        r_sz       = hi_q - p;
        left_r.lo  = lo_q;
        left_r.hi  = p - RW'(1);
        right_r.lo = p + RW'(1);
        right_r.hi = hi_q;
    end

    // Next-state and stack control.
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        pa_d      = pa_q;
        pb_d      = pb_q;
        err_d     = err_q;
        st_clr    = 1'b0;
        st_push   = 1'b0;
        st_pop    = 1'b0;
        push_data = pb_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (K >= 2) begin
                        st_clr       = 1'b1;
                        st_push      = 1'b1;
                        push_data.lo = '0;
                        push_data.hi = RW'(K - 1);
                        state_d      = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (st_empty) begin
                    state_d = ST_DONE;
                end else begin
                    st_pop  = 1'b1;
                    lo_d    = top.lo;
                    hi_d    = top.hi;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (range_ready) state_d = ST_WAIT_PIVOT;
            end
            ST_WAIT_PIVOT: begin
                if (pivot_valid) begin
                    if (bad) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (l_ok && r_ok) begin
                        // Larger pushed first so the smaller sits on top.
                        if (l_sz >= r_sz) begin
                            pa_d = left_r;
                            pb_d = right_r;
                        end else begin
                            pa_d = right_r;
                            pb_d = left_r;
                        end
                        state_d = ST_PUSH_A;
                    end else if (l_ok) begin
                        pb_d    = left_r;
                        state_d = ST_PUSH_B;
                    end else if (r_ok) begin
                        pb_d    = right_r;
                        state_d = ST_PUSH_B;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_PUSH_A: begin
                if (st_full) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    st_push   = 1'b1;
                    push_data = pa_q;
                    state_d   = ST_PUSH_B;
                end
            end
            ST_PUSH_B: begin
                if (st_full) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    st_push   = 1'b1;
                    push_data = pb_q;
                    state_d   = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            err_q   <= err_d;
        end
    end

    // Range outputs are zero outside OFFER so reset leaves every output at 0.
    always_comb begin
        range_valid = (state_q == ST_OFFER);
        range_lo    = range_valid ? lo_q[S-1:0] : '0;
        range_hi    = range_valid ? hi_q[S-1:0] : '0;
        range_cnt   = range_valid ? S'(hi_q - lo_q + RW'(1)) : '0;
        busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done        = (state_q == ST_DONE);
        error       = err_q;
    end

endmodule
